// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - op encoding shared by the multi-channel accumulator
package accum_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/accum_mc_if.sv
// rtl/accum_mc_if.sv - op request / result handshake bundle for accum_mc
interface accum_mc_if
  import accum_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int CH_W = ch_width(CHANNELS);

  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [CH_W-1:0]  in_ch;
  logic [WIDTH-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [WIDTH-1:0] out_y;
  logic             out_cbf;
  logic             out_zero;

  modport master (
    output in_valid, in_op, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_y, out_cbf, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_y, out_cbf, out_zero
  );

endinterface

// File: rtl/accum_alu.sv
// rtl/accum_alu.sv - combinational add/sub/load/clear; ACCUM_SAT_EN selects clamping
module accum_alu
  import accum_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             cbf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit is the carry for ADD and the borrow for SUB.
  assign sum  = {1'b0, acc} + {1'b0, operand};
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result = '0;
    cbf    = 1'b0;
    unique case (op)
      OP_ADD: begin
`ifdef ACCUM_SAT_EN
        result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        result = sum[WIDTH-1:0];
`endif
        cbf = sum[WIDTH];
      end
      OP_SUB: begin
`ifdef ACCUM_SAT_EN
        result = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        result = diff[WIDTH-1:0];
`endif
        cbf = diff[WIDTH];
      end
      OP_LOAD: result = operand;
      OP_CLR:  result = '0;
    endcase
  end

endmodule

// File: rtl/accum_mc.sv
// rtl/accum_mc.sv - multi-channel accumulator with registered result; ACCUM_SAT_EN enables clamping
module accum_mc
  import accum_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input logic       clk,
  input logic       reset,
  accum_mc_if.slave bus
);

  localparam int CH_W = ch_width(CHANNELS);

  logic [WIDTH-1:0] acc [CHANNELS];
  logic [WIDTH-1:0] acc_sel;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cbf;
  logic             ch_ok;
  logic             accept;

  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_cbf_q;
  logic             out_zero_q;

  assign ch_ok         = 32'(bus.in_ch) < 32'(CHANNELS);
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready && ch_ok;

  // Read the target channel directly from the register array, so a second op on
  // the same channel in the next cycle sees the value the first one wrote.
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == bus.in_ch) acc_sel = acc[i];
    end
  end

  accum_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (bus.in_op),
    .acc     (acc_sel),
    .operand (bus.in_data),
    .result  (alu_y),
    .cbf     (alu_cbf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (CH_W'(i) == bus.in_ch) acc[i] <= alu_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_y_q     <= '0;
      out_cbf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= bus.in_ch;
      out_y_q     <= alu_y;
      out_cbf_q   <= alu_cbf;
      out_zero_q  <= (alu_y == '0);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_cbf   = out_cbf_q;
  assign bus.out_zero  = out_zero_q;

endmodule
